// File: rtl/axi_burst_write_engine.sv
// AXI4 write-channel engine: turns one line-write request into a single INCR burst.
// Runs one transaction at a time: AW handshake, W beats, then B response.
//
// state | meaning
// IDLE  | ready for a request, addr_ok high
// AW    | burst address presented, waiting for awready
// W     | streaming beats cnt..burst from the latched line
// B     | waiting for the write response
module axi_burst_write_engine #(
    parameter logic [3:0] AWCACHE = 4'b0000,
    parameter int         WORDS   = 16
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  req,
    input  logic [31:0]           addr,
    input  logic [3:0]            burst,
    input  logic [32*WORDS-1:0]   line_wdata,
    input  logic [4*WORDS-1:0]    line_strb,
    output logic                  addr_ok,
    output logic                  data_ok,
    output logic                  bus_err,
    output logic [31:0]           awaddr,
    output logic [7:0]            awlen,
    output logic [2:0]            awsize,
    output logic [1:0]            awburst,
    output logic [3:0]            awcache,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [31:0]           wdata,
    output logic [3:0]            wstrb,
    output logic                  wlast,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AW   = 2'd1,
        W    = 2'd2,
        B    = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [3:0]          burst_q;
    logic [3:0]          cnt;
    logic [32*WORDS-1:0] line_q;
    logic [4*WORDS-1:0]  strb_q;
    logic [8:0]          word_lsb;
    logic [5:0]          strb_lsb;

    assign awsize   = 3'b010;
    assign awburst  = 2'b01;
    assign awcache  = AWCACHE;
    assign word_lsb = {cnt, 5'b0};
    assign strb_lsb = {cnt, 2'b0};

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The request is captured whole so the requester is free once addr_ok has been seen.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            awaddr  <= '0;
            awlen   <= '0;
            burst_q <= '0;
            cnt     <= '0;
            line_q  <= '0;
            strb_q  <= '0;
        end else if (state == IDLE && req) begin
            awaddr  <= addr;
            awlen   <= {4'b0, burst};
            burst_q <= burst;
            cnt     <= '0;
            line_q  <= line_wdata;
            strb_q  <= line_strb;
        end else if (state == W && wready && cnt != burst_q) begin
            cnt <= cnt + 4'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        addr_ok   = 1'b0;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        wlast     = 1'b0;
        wdata     = '0;
        wstrb     = '0;
        bready    = 1'b0;
        data_ok   = 1'b0;
        bus_err   = 1'b0;
        case (state)
            IDLE: begin
                addr_ok = 1'b1;
                if (req) state_nxt = AW;
            end
            AW: begin
                awvalid = 1'b1;
                if (awready) state_nxt = W;
            end
            W: begin
                wvalid = 1'b1;
                wdata  = line_q[word_lsb +: 32];
                wstrb  = strb_q[strb_lsb +: 4];
                wlast  = (cnt == burst_q);
                if (wready && wlast) state_nxt = B;
            end
            B: begin
                bready = 1'b1;
                if (bvalid) begin
                    data_ok   = 1'b1;
                    bus_err   = (bresp != 2'b00);
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_burst_write_engine.sv
// Self-checking bench for axi_burst_write_engine: a bench-side AXI slave drives the
// channels and each transaction is compared against a word-array model of the request.
module tb_axi_burst_write_engine;

    logic         aclk = 1'b0;
    logic         aresetn;
    logic         req;
    logic [31:0]  addr;
    logic [3:0]   burst;
    logic [511:0] line_wdata;
    logic [63:0]  line_strb;
    logic         addr_ok, data_ok, bus_err;
    logic [31:0]  awaddr;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic [3:0]   awcache;
    logic         awvalid, awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wlast, wvalid, wready;
    logic [1:0]   bresp;
    logic         bvalid, bready;

    always #5 aclk = ~aclk;

    axi_burst_write_engine dut (
        .aclk(aclk), .aresetn(aresetn), .req(req), .addr(addr), .burst(burst),
        .line_wdata(line_wdata), .line_strb(line_strb),
        .addr_ok(addr_ok), .data_ok(data_ok), .bus_err(bus_err),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awcache(awcache), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    int checks = 0;
    int errors = 0;

    // Request content as the requester sees it: one word and one strobe nibble per beat.
    logic [31:0] t_words [16];
    logic [3:0]  t_strbs [16];

    // What the slave saw during the last transaction.
    int          obs_accept, obs_aw_first, obs_aw_stall, obs_ok_cyc, obs_ok_cnt;
    int          obs_last_cyc, obs_unstable, obs_timeout, obs_addr_ok_at_ok;
    logic [31:0] obs_awaddr;
    logic [7:0]  obs_awlen;
    logic        obs_bus_err;
    logic [31:0] q_data [$];
    logic [3:0]  q_strb [$];
    logic        q_last [$];

    task automatic pack_line();
        for (int i = 15; i >= 0; i--) begin
            line_wdata = {line_wdata[479:0], t_words[i]};
            line_strb  = {line_strb[59:0], t_strbs[i]};
        end
    endtask

    task automatic random_line();
        for (int i = 0; i < 16; i++) begin
            t_words[i] = $urandom;
            t_strbs[i] = 4'($urandom);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge aclk);
            req = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        end
    endtask

    // Slave behaviour: awready low for aw_delay cycles; wready always (0), toggling (1)
    // or random (2); bvalid after b_delay cycles in B; optional stray bvalid earlier.
    task automatic do_txn(input logic [31:0] a, input logic [3:0] b, input logic [1:0] resp,
                          input int aw_delay, input int w_mode, input int b_delay,
                          input bit stray, input bit hold_req);
        int          phase, aw_wait, w_cyc, b_wait;
        bit          done;
        logic        prev_aw_stall, prev_w_stall, prev_wlast;
        logic [31:0] prev_awaddr, prev_wdata;
        logic [3:0]  prev_wstrb;
        q_data.delete(); q_strb.delete(); q_last.delete();
        obs_aw_first = -1; obs_aw_stall = 0; obs_ok_cyc = -1; obs_ok_cnt = 0;
        obs_last_cyc = -1; obs_unstable = 0; obs_timeout = 0; obs_addr_ok_at_ok = -1;
        obs_awaddr = '0; obs_awlen = '0; obs_bus_err = 1'b0;
        prev_aw_stall = 1'b0; prev_w_stall = 1'b0; prev_wlast = 1'b0;
        prev_awaddr = '0; prev_wdata = '0; prev_wstrb = '0;
        @(negedge aclk);
        pack_line();
        addr = a; burst = b; req = 1'b1;
        awready = 1'b0; wready = 1'b0; bresp = 2'($urandom);
        bvalid = stray ? 1'($urandom) : 1'b0;
        #1;
        obs_accept = int'(addr_ok);
        if (data_ok) obs_ok_cnt++;
        phase = 0; aw_wait = 0; w_cyc = 0; b_wait = 0; done = 1'b0;
        for (int cyc = 1; cyc <= 400 && !done; cyc++) begin
            @(negedge aclk);
            req = hold_req;
            addr = $urandom; burst = 4'($urandom);
            line_wdata = ~line_wdata; line_strb = ~line_strb;
            awready = (phase == 0) && (aw_wait >= aw_delay);
            if (phase != 1)      wready = 1'b0;
            else if (w_mode == 0) wready = 1'b1;
            else if (w_mode == 1) wready = w_cyc[0];
            else                  wready = 1'($urandom);
            bvalid = (phase == 2) ? (b_wait >= b_delay) : (stray ? 1'($urandom) : 1'b0);
            bresp  = (phase == 2) ? resp : 2'($urandom);
            #1;
            if (awvalid) begin
                obs_awaddr = awaddr; obs_awlen = awlen;
                if (obs_aw_first < 0) obs_aw_first = cyc;
                if (!awready) obs_aw_stall++;
            end
            if (prev_aw_stall && (!awvalid || awaddr !== prev_awaddr)) obs_unstable++;
            if (prev_w_stall && (!wvalid || wdata !== prev_wdata || wstrb !== prev_wstrb ||
                                 wlast !== prev_wlast)) obs_unstable++;
            prev_aw_stall = awvalid && !awready; prev_awaddr = awaddr;
            prev_w_stall  = wvalid && !wready;
            prev_wdata = wdata; prev_wstrb = wstrb; prev_wlast = wlast;
            if (wvalid && wready) begin
                q_data.push_back(wdata); q_strb.push_back(wstrb); q_last.push_back(wlast);
            end
            if (data_ok) begin
                obs_ok_cnt++;
                if (phase == 2) begin
                    obs_ok_cyc = cyc; obs_bus_err = bus_err;
                    obs_addr_ok_at_ok = int'(addr_ok); done = 1'b1;
                end
            end
            if (phase == 0) begin
                if (awvalid && awready) phase = 1;
                else aw_wait++;
            end else if (phase == 1) begin
                w_cyc++;
                if (wvalid && wready && wlast) begin
                    phase = 2; obs_last_cyc = cyc;
                end
            end else begin
                b_wait++;
            end
        end
        if (!done) obs_timeout = 1;
    endtask

    task automatic test_reset();
        aresetn = 1'b0; req = 1'b0; addr = '0; burst = '0; line_wdata = '0; line_strb = '0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        repeat (2) @(negedge aclk);
        bvalid = 1'b1;
        #1;
        checks++; if ({addr_ok, data_ok, bus_err} !== 3'b100) begin errors++; $display("FAIL reset_flags got %b exp 100", {addr_ok, data_ok, bus_err}); end
        checks++; if ({awvalid, wvalid, wlast, bready} !== 4'b0000) begin errors++; $display("FAIL reset_valids got %b exp 0000", {awvalid, wvalid, wlast, bready}); end
        checks++; if ({awaddr, awlen, wdata, wstrb} !== 76'd0) begin errors++; $display("FAIL reset_regs got %h exp 0", {awaddr, awlen, wdata, wstrb}); end
        checks++; if ({awsize, awburst, awcache} !== 9'b010_01_0000) begin errors++; $display("FAIL const_aw got %b exp 010010000", {awsize, awburst, awcache}); end
        @(negedge aclk);
        aresetn = 1'b1; bvalid = 1'b0;
        idle(1);
    endtask

    task automatic test_single();
        random_line();
        t_words[0] = 32'hDEAD_BEEF; t_strbs[0] = 4'b1111;
        do_txn(32'h1FC0_0100, 4'd0, 2'b00, 0, 0, 0, 1'b0, 1'b0);
        checks++; if (obs_accept !== 1) begin errors++; $display("FAIL single_accept got %0d exp 1", obs_accept); end
        checks++; if (obs_awaddr !== 32'h1FC0_0100) begin errors++; $display("FAIL single_awaddr got %h exp 1fc00100", obs_awaddr); end
        checks++; if (obs_awlen !== 8'h00) begin errors++; $display("FAIL single_awlen got %h exp 00", obs_awlen); end
        checks++; if (obs_aw_first !== 1) begin errors++; $display("FAIL single_aw_cycle got %0d exp 1", obs_aw_first); end
        checks++; if (q_data.size() !== 1) begin errors++; $display("FAIL single_beats got %0d exp 1", q_data.size()); end
        else begin
            checks++; if (q_data[0] !== 32'hDEAD_BEEF || q_last[0] !== 1'b1 || q_strb[0] !== 4'hF) begin errors++; $display("FAIL single_beat got %h/%b/%h exp deadbeef/1/f", q_data[0], q_last[0], q_strb[0]); end
        end
        checks++; if (obs_ok_cyc !== 3) begin errors++; $display("FAIL single_latency got %0d exp 3", obs_ok_cyc); end
        checks++; if (obs_ok_cnt !== 1 || obs_bus_err !== 1'b0) begin errors++; $display("FAIL single_resp got ok=%0d err=%b exp ok=1 err=0", obs_ok_cnt, obs_bus_err); end
        idle(1);
    endtask

    task automatic test_full_line();
        for (int i = 0; i < 16; i++) begin
            t_words[i] = 32'h1000_0000 + 32'(i); t_strbs[i] = 4'hF;
        end
        do_txn(32'h0000_2000, 4'd15, 2'b00, 0, 0, 0, 1'b0, 1'b0);
        checks++; if (obs_awlen !== 8'h0F) begin errors++; $display("FAIL full_awlen got %h exp 0f", obs_awlen); end
        checks++; if (q_data.size() !== 16) begin errors++; $display("FAIL full_beats got %0d exp 16", q_data.size()); end
        for (int i = 0; i < q_data.size() && i < 16; i++) begin
            checks++; if (q_data[i] !== 32'h1000_0000 + 32'(i) || q_last[i] !== (i == 15)) begin errors++; $display("FAIL full_beat%0d got %h/%b exp %h/%b", i, q_data[i], q_last[i], 32'h1000_0000 + 32'(i), i == 15); end
        end
        checks++; if (obs_ok_cyc !== 18) begin errors++; $display("FAIL full_latency got %0d exp 18", obs_ok_cyc); end
        idle(1);
    endtask

    task automatic test_backpressure();
        random_line();
        do_txn(32'h8000_0040, 4'd3, 2'b00, 3, 1, 1, 1'b0, 1'b0);
        checks++; if (obs_aw_first !== 1 || obs_aw_stall !== 3) begin errors++; $display("FAIL bp_aw got first=%0d stall=%0d exp 1/3", obs_aw_first, obs_aw_stall); end
        checks++; if (obs_awaddr !== 32'h8000_0040) begin errors++; $display("FAIL bp_awaddr got %h exp 80000040", obs_awaddr); end
        checks++; if (obs_unstable !== 0) begin errors++; $display("FAIL bp_stable got %0d changes exp 0", obs_unstable); end
        checks++; if (q_data.size() !== 4) begin errors++; $display("FAIL bp_beats got %0d exp 4", q_data.size()); end
        for (int i = 0; i < q_data.size() && i < 4; i++) begin
            checks++; if (q_data[i] !== t_words[i] || q_strb[i] !== t_strbs[i]) begin errors++; $display("FAIL bp_beat%0d got %h/%h exp %h/%h", i, q_data[i], q_strb[i], t_words[i], t_strbs[i]); end
        end
        checks++; if (obs_ok_cyc - obs_last_cyc !== 2 || obs_ok_cnt !== 1) begin errors++; $display("FAIL bp_b got gap=%0d ok=%0d exp 2/1", obs_ok_cyc - obs_last_cyc, obs_ok_cnt); end
        idle(1);
    endtask

    task automatic test_strobe_err();
        random_line();
        t_strbs[0] = 4'b1100; t_strbs[1] = 4'b0011;
        do_txn(32'h0000_0010, 4'd1, 2'b10, 0, 0, 2, 1'b0, 1'b0);
        checks++; if (q_strb.size() !== 2) begin errors++; $display("FAIL strb_beats got %0d exp 2", q_strb.size()); end
        else begin
            checks++; if (q_strb[0] !== 4'b1100 || q_strb[1] !== 4'b0011) begin errors++; $display("FAIL strb_values got %b/%b exp 1100/0011", q_strb[0], q_strb[1]); end
        end
        checks++; if (obs_ok_cnt !== 1 || obs_bus_err !== 1'b1) begin errors++; $display("FAIL err_resp got ok=%0d err=%b exp 1/1", obs_ok_cnt, obs_bus_err); end
        checks++; if (obs_ok_cyc - obs_last_cyc !== 3) begin errors++; $display("FAIL err_bdelay got %0d exp 3", obs_ok_cyc - obs_last_cyc); end
        @(negedge aclk);
        req = 1'b0; bvalid = 1'b0;
        #1;
        checks++; if ({data_ok, bus_err} !== 2'b00) begin errors++; $display("FAIL err_pulse got %b exp 00", {data_ok, bus_err}); end
        idle(1);
    endtask

    task automatic test_reset_mid_burst();
        int  nb, ok_seen;
        bit  hit;
        random_line();
        pack_line();
        nb = 0; ok_seen = 0; hit = 1'b0;
        @(negedge aclk);
        addr = 32'h0000_4000; burst = 4'd15; req = 1'b1;
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
        for (int cyc = 1; cyc <= 40 && !hit; cyc++) begin
            @(negedge aclk);
            req = 1'b0;
            #1;
            if (wvalid && nb == 2) begin
                hit = 1'b1;
                checks++; if (wdata !== t_words[2]) begin errors++; $display("FAIL rst_beat2 got %h exp %h", wdata, t_words[2]); end
                aresetn = 1'b0;
                #1;
                checks++; if ({awvalid, wvalid, bready, data_ok, addr_ok} !== 5'b00001) begin errors++; $display("FAIL rst_drop got %b exp 00001", {awvalid, wvalid, bready, data_ok, addr_ok}); end
            end else if (wvalid && wready) begin
                nb++;
            end
        end
        if (!hit) begin
            checks++; errors++; $display("FAIL rst_no_beat2 got beats=%0d exp beat 2 presented", nb);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            #1;
            if (data_ok) ok_seen++;
        end
        checks++; if (ok_seen !== 0) begin errors++; $display("FAIL rst_no_ok got %0d exp 0", ok_seen); end
        @(negedge aclk);
        aresetn = 1'b1; bvalid = 1'b0; awready = 1'b0; wready = 1'b0;
        #1;
        checks++; if (addr_ok !== 1'b1) begin errors++; $display("FAIL rst_addr_ok got %b exp 1", addr_ok); end
        random_line();
        do_txn(32'h0000_5000, 4'd2, 2'b00, 0, 0, 0, 1'b0, 1'b0);
        checks++; if (q_data.size() !== 3 || obs_ok_cnt !== 1 || obs_awaddr !== 32'h0000_5000) begin errors++; $display("FAIL rst_after got beats=%0d ok=%0d addr=%h exp 3/1/00005000", q_data.size(), obs_ok_cnt, obs_awaddr); end
        else begin
            checks++; if (q_data[0] !== t_words[0] || q_data[2] !== t_words[2] || q_last[2] !== 1'b1) begin errors++; $display("FAIL rst_after_data got %h/%h exp %h/%h", q_data[0], q_data[2], t_words[0], t_words[2]); end
        end
        idle(1);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        logic [3:0]  b;
        for (int t = 0; t < 4; t++) begin
            random_line();
            a = $urandom; a[1:0] = 2'b00;
            b = 4'($urandom);
            do_txn(a, b, 2'b00, 0, 0, 0, 1'b1, 1'b1);
            checks++; if (obs_accept !== 1) begin errors++; $display("FAIL b2b_accept%0d got %0d exp 1", t, obs_accept); end
            checks++; if (obs_ok_cnt !== 1 || obs_addr_ok_at_ok !== 0) begin errors++; $display("FAIL b2b_ok%0d got ok=%0d addr_ok=%0d exp 1/0", t, obs_ok_cnt, obs_addr_ok_at_ok); end
            checks++; if (q_data.size() !== int'(b) + 1 || obs_awaddr !== a) begin errors++; $display("FAIL b2b_txn%0d got beats=%0d addr=%h exp %0d/%h", t, q_data.size(), obs_awaddr, int'(b) + 1, a); end
            else begin
                checks++; if (q_data[b] !== t_words[b] || q_strb[b] !== t_strbs[b]) begin errors++; $display("FAIL b2b_last%0d got %h exp %h", t, q_data[b], t_words[b]); end
            end
        end
        idle(2);
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [3:0]  b;
        logic [1:0]  r;
        int          bd, bad;
        for (int t = 0; t < 25; t++) begin
            random_line();
            a = $urandom; a[1:0] = 2'b00;
            b = 4'($urandom); r = 2'($urandom);
            bd = int'($urandom_range(0, 3));
            do_txn(a, b, r, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), bd, 1'($urandom), 1'b0);
            bad = 0;
            if (q_data.size() != int'(b) + 1) bad++;
            else for (int i = 0; i <= int'(b); i++)
                if (q_data[i] !== t_words[i] || q_strb[i] !== t_strbs[i] || q_last[i] !== (i == int'(b))) bad++;
            checks++; if (bad !== 0) begin errors++; $display("FAIL rnd_beats%0d got %0d bad of %0d exp 0 bad of %0d", t, bad, q_data.size(), int'(b) + 1); end
            checks++; if (obs_awaddr !== a || obs_awlen !== {4'b0, b}) begin errors++; $display("FAIL rnd_aw%0d got %h/%h exp %h/%h", t, obs_awaddr, obs_awlen, a, {4'b0, b}); end
            checks++; if (obs_ok_cnt !== 1 || obs_bus_err !== (r != 2'b00) || obs_ok_cyc - obs_last_cyc !== bd + 1) begin errors++; $display("FAIL rnd_b%0d got ok=%0d err=%b gap=%0d exp 1/%b/%0d", t, obs_ok_cnt, obs_bus_err, obs_ok_cyc - obs_last_cyc, r != 2'b00, bd + 1); end
            checks++; if (obs_unstable !== 0 || obs_timeout !== 0 || obs_accept !== 1) begin errors++; $display("FAIL rnd_proto%0d got unstable=%0d timeout=%0d accept=%0d exp 0/0/1", t, obs_unstable, obs_timeout, obs_accept); end
            idle(int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full_line();
        test_backpressure();
        test_strobe_err();
        test_reset_mid_burst();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
